// File: rtl/statseg_pkg.sv
// ============================================================================
// Module      : statseg_pkg
// Description : Mode encodings and the status-word update function shared by
//               the status segment stack.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package statseg_pkg;

    localparam logic [1:0] SS_LOAD = 2'b00;
    localparam logic [1:0] SS_SET  = 2'b01;
    localparam logic [1:0] SS_CLR  = 2'b10;
    localparam logic [1:0] SS_TGL  = 2'b11;

    // Widest status word the update function handles; narrower words are
    // zero-extended in and truncated out, which is exact for bitwise ops.
    localparam int SS_MAX_W = 64;

    typedef logic [SS_MAX_W-1:0] ss_word_t;

    function automatic ss_word_t ss_apply(input logic [1:0] mode,
                                          input ss_word_t   live,
                                          input ss_word_t   operand);
        ss_word_t res;
        case (mode)
            SS_LOAD: res = operand;
            SS_SET:  res = live | operand;
            SS_CLR:  res = live & ~operand;
            default: res = live ^ operand;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/statseg_lifo.sv
// ============================================================================
// Module      : statseg_lifo
// Description : Shadow LIFO holding saved status words and the fill count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module statseg_lifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_en,
    input  logic                       pop_en,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import statseg_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    w_top;

    // Callers qualify push_en/pop_en against full/empty, so no guards here.
    always_comb begin
        count_d = count_q;
        if (push_en) begin
            count_d = count_q + 1'b1;
        end else if (pop_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[count_q[IW-1:0]] <= wdata;
        end
    end

    assign w_top = count_q - 1'b1;
    assign rdata = empty ? '0 : mem_q[w_top[IW-1:0]];
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/statseg_stack.sv
// ============================================================================
// Module      : statseg_stack
// Description : Live status-segment register with bitwise update modes and a
//               shadow LIFO for context save/restore.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module statseg_stack #(
    parameter int               WIDTH     = 20,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       loadsig,
    input  logic [1:0]                 mode,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       err
);
    import statseg_pkg::*;

    logic [WIDTH-1:0] live_q;
    logic [WIDTH-1:0] live_d;
    logic             err_q;
    logic             err_d;
    logic [WIDTH-1:0] w_rdata;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_err_set;

    // Simultaneous push and pop cancel: the stack is untouched, no error.
    assign w_do_push = push & ~pop & ~w_full;
    assign w_do_pop  = pop & ~push & ~w_empty;
    assign w_err_set = (push & ~pop & w_full) | (pop & ~push & w_empty);

    always_comb begin
        live_d = live_q;
        err_d  = err_q;
        if (w_do_pop) begin
            live_d = w_rdata;
        end else if (loadsig) begin
            live_d = WIDTH'(ss_apply(mode, ss_word_t'(live_q), ss_word_t'(data_in)));
        end
        if (w_err_set) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            live_q <= RESET_VAL;
            err_q  <= 1'b0;
        end else begin
            live_q <= live_d;
            err_q  <= err_d;
        end
    end

    statseg_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push_en (w_do_push),
        .pop_en  (w_do_pop),
        .wdata   (live_q),
        .rdata   (w_rdata),
        .count   (count),
        .full    (w_full),
        .empty   (w_empty)
    );

    assign data_out = live_q;
    assign full     = w_full;
    assign empty    = w_empty;
    assign err      = err_q;

endmodule

`default_nettype wire
